// File: rtl/sample_store_arbiter.sv
// Sample store arbiter: merges two channel sample strobes into one memory write
// port with round-robin arbitration, then streams stored words back out on request.
module sample_store_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              _mrst,
  input  logic              i_run,
  input  logic              i_save_a,
  input  logic              i_save_b,
  input  logic [31:0]       i_data_a,
  input  logic [31:0]       i_data_b,
  input  logic              i_dump,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [32:0]       o_mem_wdata,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [32:0]       i_mem_rdata,
  output logic              o_rd_valid,
  output logic [32:0]       o_rd_data,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, CAPTURE, RD_ADDR, RD_WAIT, RD_VALID} state_t;
  state_t state_reg, state_next;

  logic [1:0]        strobe;
  logic [1:0]        grant;
  logic [1:0]        drop;
  logic [1:0]        slot_valid;
  logic [31:0]       data_in [2];
  logic [31:0]       word_a;
  logic [31:0]       word_b;

  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [ADDR_W-1:0] wptr_reg;
  logic [ADDR_W-1:0] rptr_reg;
  logic [32:0]       wdata_reg;
  logic [32:0]       rd_data_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;
  logic              last_a_reg;

  logic in_capture;
  logic enter_capture;
  logic capture_exit;
  logic start_dump;
  logic full;
  logic rd_accept;
  logic rd_last;

  assign strobe     = {i_save_b, i_save_a};
  assign data_in[0] = i_data_a;
  assign data_in[1] = i_data_b;

  assign in_capture    = (state_reg == CAPTURE);
  assign enter_capture = (state_reg == IDLE) && i_run;
  assign start_dump    = (state_reg == IDLE) && !i_run && i_dump && (count_reg != '0);
  assign full          = (count_reg == DEPTH_CNT);
  // A full store can never drain its pending slots, so stopping capture discards them.
  assign capture_exit  = in_capture && !i_run && ((slot_valid == 2'b00) || full);
  assign rd_accept     = (state_reg == RD_VALID) && i_rd_ready;
  assign rd_last       = (({1'b0, rptr_reg} + (ADDR_W+1)'(1)) == count_reg);

  // last_a_reg=0 after reset, so A wins the first contention.
  assign grant[0] = in_capture && !full && slot_valid[0] && (!slot_valid[1] || !last_a_reg);
  assign grant[1] = in_capture && !full && slot_valid[1] && !grant[0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic        valid_reg;
    logic [31:0] word_reg;

    assign slot_valid[gi] = valid_reg;
    assign drop[gi]       = in_capture && strobe[gi] && valid_reg && !grant[gi];

    always_ff @(posedge i_clk or negedge _mrst) begin
      if (!_mrst) begin
        valid_reg <= 1'b0;
        word_reg  <= '0;
      end else if (enter_capture || capture_exit) begin
        valid_reg <= 1'b0;
      end else if (in_capture) begin
        if (strobe[gi] && (!valid_reg || grant[gi])) begin
          valid_reg <= 1'b1;
          word_reg  <= data_in[gi];
        end else if (grant[gi]) begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  assign word_a = g_slot[0].word_reg;
  assign word_b = g_slot[1].word_reg;

  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_run) begin
          state_next = CAPTURE;
        end else if (start_dump) begin
          state_next = RD_ADDR;
        end
      end
      CAPTURE: begin
        if (capture_exit) begin
          state_next = IDLE;
        end
      end
      RD_ADDR:  state_next = RD_WAIT;
      RD_WAIT:  state_next = RD_VALID;
      RD_VALID: begin
        if (rd_accept) begin
          state_next = rd_last ? IDLE : RD_ADDR;
        end
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      wptr_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      last_a_reg   <= 1'b0;
      rptr_reg     <= '0;
      rd_data_reg  <= '0;
    end else begin
      we_reg <= |grant;
      if (|grant) begin
        waddr_reg  <= wptr_reg;
        wdata_reg  <= grant[0] ? {1'b0, word_a} : {1'b1, word_b};
        wptr_reg   <= wptr_reg + ADDR_W'(1);
        count_reg  <= count_reg + (ADDR_W+1)'(1);
        last_a_reg <= grant[0];
      end

      if (enter_capture) begin
        wptr_reg     <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else if (|drop) begin
        overflow_reg <= 1'b1;
      end

      if (start_dump) begin
        rptr_reg <= '0;
      end
      if (state_reg == RD_WAIT) begin
        rd_data_reg <= i_mem_rdata;
      end
      if (rd_accept) begin
        rptr_reg <= rptr_reg + ADDR_W'(1);
        if (rd_last) begin
          count_reg <= '0;
        end
      end
    end
  end

  assign o_mem_we    = we_reg;
  assign o_mem_waddr = waddr_reg;
  assign o_mem_wdata = wdata_reg;
  assign o_mem_raddr = rptr_reg;
  assign o_rd_valid  = (state_reg == RD_VALID);
  assign o_rd_data   = rd_data_reg;
  assign o_count     = count_reg;
  assign o_full      = full;
  assign o_overflow  = overflow_reg;
  assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sample_store_arbiter.sv
// Directed bench for sample_store_arbiter with a 4-word store and a
// synchronous-read memory model attached to the write and read ports.
module tb_sample_store_arbiter;
  localparam int ADDR_W = 2;

  logic              i_clk = 1'b0;
  logic              _mrst = 1'b0;
  logic              i_run = 1'b0;
  logic              i_save_a = 1'b0;
  logic              i_save_b = 1'b0;
  logic [31:0]       i_data_a = '0;
  logic [31:0]       i_data_b = '0;
  logic              i_dump = 1'b0;
  logic              i_rd_ready = 1'b0;
  logic [32:0]       i_mem_rdata;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_waddr;
  logic [32:0]       o_mem_wdata;
  logic [ADDR_W-1:0] o_mem_raddr;
  logic              o_rd_valid;
  logic [32:0]       o_rd_data;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_overflow;
  logic              o_busy;

  logic [32:0] mem [4];
  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int wr_addr0 = 0;
  int base_total;
  int base_addr0;
  int waited;
  logic [32:0] exp_rd [3];

  sample_store_arbiter #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), ._mrst(_mrst), .i_run(i_run),
    .i_save_a(i_save_a), .i_save_b(i_save_b),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_dump(i_dump),
    .o_mem_we(o_mem_we), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
    .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
    .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_mem_we) begin
      mem[o_mem_waddr] <= o_mem_wdata;
      wr_total <= wr_total + 1;
      if (o_mem_waddr == 0) wr_addr0 <= wr_addr0 + 1;
    end
    i_mem_rdata <= mem[o_mem_raddr];
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},       o_mem_we,    0);
    check({tag, "_waddr"},    o_mem_waddr, 0);
    check({tag, "_wdata"},    o_mem_wdata, 0);
    check({tag, "_raddr"},    o_mem_raddr, 0);
    check({tag, "_rd_valid"}, o_rd_valid,  0);
    check({tag, "_rd_data"},  o_rd_data,   0);
    check({tag, "_count"},    o_count,     0);
    check({tag, "_full"},     o_full,      0);
    check({tag, "_overflow"}, o_overflow,  0);
    check({tag, "_busy"},     o_busy,      0);
  endtask

  task automatic pulse_reset();
    _mrst = 1'b0;
    tick();
    _mrst = 1'b1;
    tick();
  endtask

  task automatic wait_rd_valid(input string tag);
    waited = 0;
    while (!o_rd_valid && waited < 10) begin
      tick();
      waited++;
    end
    check(tag, o_rd_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state and first cycle after release
    tick();
    tick();
    check_all_zero("reset");
    _mrst = 1'b1;
    tick();
    check("release_we", o_mem_we, 0);
    check("release_busy", o_busy, 0);

    // Single A sample, two-cycle strobe-to-write latency
    i_run = 1'b1;
    tick();
    check("capture_busy", o_busy, 1);
    i_save_a = 1'b1; i_data_a = 32'h0000_1A55;
    tick();
    i_save_a = 1'b0;
    check("single_we_early", o_mem_we, 0);
    tick();
    check("single_we", o_mem_we, 1);
    check("single_waddr", o_mem_waddr, 0);
    check("single_wdata", o_mem_wdata, 33'h0_0000_1A55);
    check("single_count", o_count, 1);
    tick();
    check("single_we_off", o_mem_we, 0);
    i_run = 1'b0;
    tick();
    check("single_idle", o_busy, 0);

    // Simultaneous strobes, round-robin A then B twice
    pulse_reset();
    i_run = 1'b1;
    tick();
    i_save_a = 1'b1; i_data_a = 32'h11; i_save_b = 1'b1; i_data_b = 32'h22;
    tick();
    i_save_a = 1'b0; i_save_b = 1'b0;
    tick();
    check("rr1_waddr", o_mem_waddr, 0);
    check("rr1_wdata", o_mem_wdata, 33'h0_0000_0011);
    tick();
    check("rr2_we", o_mem_we, 1);
    check("rr2_waddr", o_mem_waddr, 1);
    check("rr2_wdata", o_mem_wdata, 33'h1_0000_0022);
    tick();
    check("rr_gap_we", o_mem_we, 0);
    i_save_a = 1'b1; i_data_a = 32'h33; i_save_b = 1'b1; i_data_b = 32'h44;
    tick();
    i_save_a = 1'b0; i_save_b = 1'b0;
    tick();
    check("rr3_waddr", o_mem_waddr, 2);
    check("rr3_wdata", o_mem_wdata, 33'h0_0000_0033);
    tick();
    check("rr4_waddr", o_mem_waddr, 3);
    check("rr4_wdata", o_mem_wdata, 33'h1_0000_0044);
    check("rr4_full", o_full, 1);
    i_run = 1'b0;
    tick();

    // Fill the store from A, then hold and overflow
    pulse_reset();
    i_run = 1'b1;
    tick();
    base_total = wr_total;
    base_addr0 = wr_addr0;
    for (int k = 0; k < 5; k++) begin
      i_save_a = 1'b1; i_data_a = 32'h100 + k;
      tick();
      i_save_a = 1'b0;
      tick();
      tick();
    end
    check("fill_count", o_count, 4);
    check("fill_full", o_full, 1);
    check("fill_ovf_before", o_overflow, 0);
    check("fill_writes", wr_total - base_total, 4);
    i_save_a = 1'b1; i_data_a = 32'h999;
    tick();
    i_save_a = 1'b0;
    check("fill_ovf_after", o_overflow, 1);
    tick();
    check("fill_we_held", o_mem_we, 0);
    check("fill_count_held", o_count, 4);
    check("fill_writes_after", wr_total - base_total, 4);
    check("fill_addr0_once", wr_addr0 - base_addr0, 1);
    check("fill_mem0", mem[0], 33'h0_0000_0100);
    check("fill_mem3", mem[3], 33'h0_0000_0103);
    i_run = 1'b0;
    pulse_reset();

    // Store three words, then dump with stalls
    exp_rd[0] = 33'h0_0000_00A1;
    exp_rd[1] = 33'h1_0000_00B2;
    exp_rd[2] = 33'h0_0000_00A3;
    i_run = 1'b1;
    tick();
    i_save_a = 1'b1; i_data_a = 32'hA1;
    tick();
    i_save_a = 1'b0; i_save_b = 1'b1; i_data_b = 32'hB2;
    tick();
    i_save_b = 1'b0; i_save_a = 1'b1; i_data_a = 32'hA3;
    tick();
    i_save_a = 1'b0;
    tick();
    tick();
    tick();
    check("dump_stored", o_count, 3);
    i_run = 1'b0;
    tick();
    check("dump_idle", o_busy, 0);
    i_save_a = 1'b1; i_data_a = 32'hDEAD;
    tick();
    i_save_a = 1'b0;
    tick();
    check("idle_strobe_count", o_count, 3);
    check("idle_strobe_ovf", o_overflow, 0);
    check("idle_strobe_we", o_mem_we, 0);
    i_dump = 1'b1;
    tick();
    i_dump = 1'b0;
    check("dump_busy", o_busy, 1);
    for (int i = 0; i < 3; i++) begin
      wait_rd_valid($sformatf("rd%0d_valid", i));
      check($sformatf("rd%0d_data", i), o_rd_data, exp_rd[i]);
      tick();
      check($sformatf("rd%0d_stall_valid", i), o_rd_valid, 1);
      check($sformatf("rd%0d_stall_data", i), o_rd_data, exp_rd[i]);
      i_rd_ready = 1'b1;
      tick();
      i_rd_ready = 1'b0;
    end
    check("dump_done_busy", o_busy, 0);
    check("dump_done_count", o_count, 0);
    check("dump_done_valid", o_rd_valid, 0);

    // Asynchronous reset during RD_VALID
    i_run = 1'b1;
    tick();
    i_save_a = 1'b1; i_data_a = 32'h55;
    tick();
    i_save_a = 1'b0;
    tick();
    tick();
    i_run = 1'b0;
    tick();
    i_dump = 1'b1;
    tick();
    i_dump = 1'b0;
    wait_rd_valid("rst_rd_valid_reached");
    _mrst = 1'b0;
    #1;
    check_all_zero("rst_rdvalid");
    tick();
    _mrst = 1'b1;
    tick();

    // Asynchronous reset with a write pending, then a fresh capture
    i_run = 1'b1;
    tick();
    i_save_a = 1'b1; i_data_a = 32'h66;
    tick();
    i_save_a = 1'b0;
    _mrst = 1'b0;
    #1;
    check_all_zero("rst_pending");
    tick();
    check("rst_pending_no_we", o_mem_we, 0);
    _mrst = 1'b1;
    tick();
    check("fresh_busy", o_busy, 1);
    i_save_a = 1'b1; i_data_a = 32'h77;
    tick();
    i_save_a = 1'b0;
    tick();
    check("fresh_we", o_mem_we, 1);
    check("fresh_waddr", o_mem_waddr, 0);
    check("fresh_wdata", o_mem_wdata, 33'h0_0000_0077);
    check("fresh_ovf", o_overflow, 0);
    check("fresh_count", o_count, 1);
    i_run = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_store_arbiter.md
SAMPLE_STORE_ARBITER -- requirements
Module: sample_store_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width; depth DEPTH = 2^ADDR_W words.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 _mrst  in  1  reset, asynchronous, active-low.
REQ-004 i_run  in  1  capture enable, level; OR of channel run flags.
REQ-005 i_save_a / i_save_b  in  1 each  one-cycle sample strobes from channel A / B.
REQ-006 i_data_a / i_data_b  in  32 each  sample word {time[23:0], pins[7:0]}, valid with its strobe.
REQ-007 i_dump  in  1  pulse; starts readout of stored words.
REQ-008 o_mem_we  out  1; o_mem_waddr  out  ADDR_W; o_mem_wdata  out  33  write port, {channel id, data}, id 0=A, 1=B.
REQ-009 o_mem_raddr  out  ADDR_W; i_mem_rdata  in  33  read port, data valid exactly 1 cycle after address.
REQ-010 o_rd_valid  out  1; o_rd_data  out  33; i_rd_ready  in  1  readout stream, valid/ready.
REQ-011 o_count  out  ADDR_W+1  words stored; o_full  out  1; o_overflow  out  1 sticky; o_busy  out  1 (state != IDLE).

Function
REQ-012 FSM states SHALL be IDLE, CAPTURE, RD_ADDR, RD_WAIT, RD_VALID.
REQ-013 IDLE -> CAPTURE on i_run=1; entry clears write pointer, o_count, o_overflow, both pending slots.
REQ-014 CAPTURE -> IDLE when i_run=0 and both pending slots empty; pending words are written before exit.
REQ-015 IDLE -> RD_ADDR on i_dump=1 with i_run=0 and o_count>0; read pointer cleared; i_dump ignored otherwise.
REQ-016 i_run=1 and i_dump=1 together in IDLE: i_run wins.
REQ-017 Each channel has one pending slot (valid bit + 32-bit word); strobe in CAPTURE latches data and sets valid at the next edge.
REQ-018 Strobe arriving while that slot is valid and not granted in the same cycle: word dropped, o_overflow set.
REQ-019 Strobe in same cycle as grant of that slot: granted word written, new word latched, valid stays 1.
REQ-020 Arbiter: one grant per cycle when any slot valid and o_count<DEPTH; round-robin, last-granted channel lowest priority; after reset A has priority.
REQ-021 Grant registers o_mem_we=1, o_mem_waddr=write pointer, o_mem_wdata={id,word} for one cycle at next edge; strobe-to-write latency exactly 2 cycles when uncontended.
REQ-022 Write pointer and o_count increment by 1 per write; o_count saturates at DEPTH; o_full = (o_count==DEPTH).
REQ-023 When o_full=1, pending slots held; further strobes on occupied slots set o_overflow; words stored are never overwritten.
REQ-024 Strobes outside CAPTURE are ignored and do not set o_overflow.
REQ-025 RD_ADDR drives o_mem_raddr=read pointer, -> RD_WAIT; RD_WAIT captures i_mem_rdata next edge, -> RD_VALID.
REQ-026 RD_VALID holds o_rd_valid=1, o_rd_data stable until i_rd_ready=1; on acceptance read pointer+1; if read pointer+1 == o_count -> IDLE with o_count cleared, else -> RD_ADDR.
REQ-027 o_mem_we SHALL be 0 in all states except the cycle after a grant.

Reset
REQ-028 _mrst=0 asynchronously forces IDLE, all outputs 0, pointers, counts, pending slots, round-robin pointer (A first) cleared, regardless of operation in progress.
REQ-029 Release of _mrst takes effect at the next rising i_clk; no write or read issued in the first cycle after release unless i_run sampled 1.

Verification
REQ-030 i_run=1, single i_save_a with data 0x00001A55 -> 2 cycles later o_mem_we=1, waddr 0, wdata 0x0_00001A55; o_count=1.
REQ-031 Simultaneous i_save_a (0x11) and i_save_b (0x22) -> writes A at addr 0 then B at addr 1 on consecutive cycles; next simultaneous pair writes A then B again (round-robin after B).
REQ-032 ADDR_W=2, 5 strobes on A spaced 3 cycles -> 4 writes, o_full=1, fifth word held, further A strobe sets o_overflow; no write to addr 0 again.
REQ-033 Store 3 words, i_run=0, i_dump pulse, i_rd_ready toggled 1/0 -> o_rd_data sequence equals written words in order, stable while stalled; FSM to IDLE, o_count=0 after third accept.
REQ-034 _mrst pulled low during RD_VALID and during pending write -> all outputs 0 immediately; after release, i_run=1 starts fresh at addr 0 with o_overflow=0.
